cell_mem_ctrl: RTL
==================

# cell_mem_ctrl

Sequencer and arbiter for one single-port cell position RAM: word 0 holds the cell's particle count, words 1..count hold `{posz, posy, posx}`. The block sits between the RAM and its two users. The force-evaluation reader requests a full-cell stream; the motion-update writer rebuilds the cell contents and commits a new count. Only one phase (read or write) owns the RAM at a time, and each phase runs to completion.

## Interface
Parameters:
- `DATA_WIDTH`, 96: RAM word width, `{posz, posy, posx}`.
- `ADDR_WIDTH`, 8: RAM address width.
- `PARTICLE_NUM`, 220: RAM depth. Maximum particles per cell is `PARTICLE_NUM-1`.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rd_start`, in, 1: one-cycle pulse that requests a cell read stream.
- `rd_valid`, out, 1: `rd_data` and `rd_id` are valid this cycle.
- `rd_data`, out, `DATA_WIDTH`: particle position word.
- `rd_id`, out, `ADDR_WIDTH`: particle index (1..count) aligned with `rd_data`.
- `rd_done`, out, 1: one-cycle pulse marking the end of the read stream.
- `wr_start`, in, 1: one-cycle pulse that opens a write phase.
- `wr_valid`, in, 1: a particle word is offered.
- `wr_ready`, out, 1: the block accepts the offered word this cycle.
- `wr_data`, in, `DATA_WIDTH`: particle word to append.
- `wr_commit`, in, 1: one-cycle pulse that ends the write phase and stores the count.
- `wr_full`, out, 1: the write pointer has reached `PARTICLE_NUM-1`.
- `busy`, out, 1: the block is not in IDLE.
- `ram_address`, out, `ADDR_WIDTH`: RAM address.
- `ram_data`, out, `DATA_WIDTH`: RAM write data.
- `ram_rden`, out, 1: RAM read enable.
- `ram_wren`, out, 1: RAM write enable.
- `ram_q`, in, `DATA_WIDTH`: RAM read data, valid 2 cycles after the address/rden cycle.

## Operation
- States: IDLE, RD_CNT, RD_WAIT, RD_STREAM, RD_DRAIN, WR, WR_CNT.
- Reset (asynchronous) state:
  - State goes to IDLE.
  - The count register, issue counter, write pointer and the 2-stage read-tag pipe clear to 0.
  - Every output is 0.
  - Reset mid-phase aborts the phase with no `rd_done` and no count write. RAM words already written stay written.
- Start requests (IDLE only):
  - `rd_start` or `wr_start` is accepted only in IDLE. Pulses arriving while `busy` is high are ignored.
  - If both pulse in the same cycle, the read wins and `wr_start` is dropped.
- Read phase:
  - RD_CNT (1 cycle): drives address 0 with `ram_rden` high.
  - RD_WAIT: lasts until the word-0 data returns.
  - Count latch: the count is taken from `ram_q[ADDR_WIDTH-1:0]` and clamped to `PARTICLE_NUM-1`.
  - Count 0: `rd_done` pulses and the block returns to IDLE.
  - Count > 0: RD_STREAM issues addresses 1..count, one per cycle, with `ram_rden` high.
  - RD_DRAIN: waits 2 cycles for the last returned word.
  - Each issued address travels through a 2-stage valid/tag pipe, producing `rd_valid` and `rd_id`.
  - `rd_data` is `ram_q` passed through combinationally.
  - `rd_done` coincides with the last `rd_valid`.
- Write phase:
  - Entering WR clears the write pointer `ptr` to 0.
  - `wr_ready = (state == WR) && !wr_full`.
  - On `wr_valid && wr_ready`: `ram_wren=1`, `ram_address=ptr+1`, `ram_data=wr_data` (combinational), then `ptr` increments.
  - `wr_full = (ptr == PARTICLE_NUM-1)`. Words offered while full are not accepted.
  - `wr_commit` in WR moves the block to WR_CNT. An entry accepted in the same cycle as `wr_commit` is included in the count.
  - WR_CNT (1 cycle): `ram_wren=1`, address 0, data = `ptr` zero-extended to `DATA_WIDTH`. The block then returns to IDLE.
- RAM port sharing: `ram_rden` and `ram_wren` are never high in the same cycle. When neither is active, `ram_address` and `ram_data` are 0.

## Timing
- Read sequence, with the `rd_start` pulse in cycle 0:
  - Cycle 1: RD_CNT, address 0.
  - Cycle 3: count latched.
  - Cycles 4..3+N: addresses 1..N issued.
  - Cycles 6..5+N: `rd_valid`.
  - Cycle 5+N: `rd_done`.
  - Cycle 6+N: `busy` low.
- Read with N=0: `rd_done` in cycle 4, `busy` low in cycle 5.
- Read throughput: 1 particle per cycle after a 6-cycle initial latency.
- Write sequence, with the `wr_start` pulse in cycle 0:
  - From cycle 1: WR, 1 entry per cycle.
  - `wr_commit` in cycle k: count write in cycle k+1, `busy` low in cycle k+2.
- `busy` rises in the cycle after an accepted start pulse.

## Test plan
- Count 3, words A/B/C at addresses 1..3, `rd_start` at cycle 0:
  - Address sequence 0,1,2,3 with `rden` high in cycles 1,4,5,6.
  - `rd_valid` in cycles 6..8 with `rd_id` 1,2,3 and data A,B,C.
  - `rd_done` in cycle 8.
- Count word 0 → no `rd_valid`, `rd_done` in cycle 4, `busy` low in cycle 5.
- Count word 250 → stream of exactly 219 particles, ids 1..219.
- Write 5 words back-to-back, then `wr_commit` → writes at addresses 1..5 followed by address 0 with data 5. A following read returns the 5 words.
- Write 219 words → `wr_full` rises, `wr_ready` falls, and a 220th `wr_valid` is not written. Commit then stores 219.
- Arbitration and reset:
  - Simultaneous `rd_start`/`wr_start` → read phase only, no writes.
  - `wr_start` during a read stream → ignored.
  - `rst` asserted mid-stream → all outputs 0 immediately and no `rd_done`.

Source files
------------

// File: rtl/cell_mem_ctrl.sv
// cell_mem_ctrl: read/write sequencer and arbiter for a single-port cell position RAM
module cell_mem_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_id,
    output logic                  rd_done,
    input  logic                  wr_start,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_commit,
    output logic                  wr_full,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    typedef enum logic [2:0] {IDLE, RD_CNT, RD_WAIT, RD_STREAM, RD_DRAIN, WR, WR_CNT} state_t;
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, iss, iss_nx, ptr, tag1, tag2, q_cnt;
    logic vld1, vld2, issue, wr_acc;

    assign q_cnt    = (ram_q[ADDR_WIDTH-1:0] > MAX_CNT) ? MAX_CNT : ram_q[ADDR_WIDTH-1:0];
    assign iss_nx   = iss + ONE;
    assign busy     = (state != IDLE);
    assign wr_full  = (ptr == MAX_CNT);
    assign wr_ready = (state == WR) && !wr_full;
    assign wr_acc   = wr_valid && wr_ready;
    assign rd_valid = vld2;
    assign rd_id    = tag2;
    // Gated so rd_data is 0 whenever no particle is being presented, including reset.
    assign rd_data  = vld2 ? ram_q : '0;

    // Next-state and RAM port control; read wins over write when both start together.
    always_comb begin
        state_nx    = state;
        ram_address = '0;
        ram_data    = '0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        issue       = 1'b0;
        rd_done     = 1'b0;
        case (state)
            IDLE: state_nx = rd_start ? RD_CNT : (wr_start ? WR : IDLE);
            RD_CNT: begin
                ram_rden = 1'b1;
                state_nx = RD_WAIT;
            end
            RD_WAIT: if (iss == ONE) state_nx = (q_cnt == '0) ? RD_DRAIN : RD_STREAM;
            RD_STREAM: begin
                ram_rden    = 1'b1;
                ram_address = iss_nx;
                issue       = 1'b1;
                if (iss_nx == cnt) state_nx = RD_DRAIN;
            end
            RD_DRAIN: if (iss == ONE) begin
                rd_done  = 1'b1;
                state_nx = IDLE;
            end
            WR: begin
                if (wr_acc) begin
                    ram_wren    = 1'b1;
                    ram_address = ptr + ONE;
                    ram_data    = wr_data;
                end
                if (wr_commit) state_nx = WR_CNT;
            end
            WR_CNT: begin
                ram_wren = 1'b1;
                ram_data = DATA_WIDTH'(ptr);
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // Counters: iss paces the count wait, the address issue and the drain; ptr counts written words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            iss <= '0;
            ptr <= '0;
        end else begin
            case (state)
                IDLE: if (state_nx == WR) ptr <= '0;
                RD_CNT: iss <= '0;
                RD_WAIT: begin
                    if (iss == ONE) begin
                        cnt <= q_cnt;
                        iss <= (q_cnt == '0) ? ONE : '0;
                    end else begin
                        iss <= iss_nx;
                    end
                end
                RD_STREAM: iss <= (iss_nx == cnt) ? '0 : iss_nx;
                RD_DRAIN: iss <= iss_nx;
                WR: if (wr_acc) ptr <= ptr + ONE;
                default: ;
            endcase
        end
    end

    // Two-stage valid/tag pipe matching the RAM read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            tag1 <= '0;
            tag2 <= '0;
        end else begin
            vld1 <= issue;
            tag1 <= issue ? ram_address : '0;
            vld2 <= vld1;
            tag2 <= tag1;
        end
    end
endmodule
